// File: rtl/mem_arb_pkg.sv
// Shared types, defaults and the address legality check for the MemDat
// two-port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2,
      LOCK1  = 2'd3
   } arb_state_t;

   // 0 = pipeline MEM stage, 1 = array loader / debug port
   typedef logic port_idx_t;

   localparam int unsigned MEM_BYTES_DEF = 2032;
   localparam int unsigned MAX_LOCK_DEF  = 16;

   // Word accesses must be 4-byte aligned and lie entirely inside the memory.
   function automatic logic addr_ok(input logic [31:0] addr, input int unsigned mem_bytes);
      return (addr[1:0] == 2'b00) && (addr <= (mem_bytes - 32'd4));
   endfunction

endpackage

// File: rtl/mem_dat_arbiter_rr_arb2.sv
// Two-way round-robin picker. Port 1 can hold the grant across cycles via
// its lock; force0 overrides everything to break a starving lock.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic clock,
   input  logic reset_n,
   input  logic req0,
   input  logic req1,
   input  logic lock1,
   input  logic force0,
   output logic gnt0,
   output logic gnt1
);

   arb_state_t state_q;
   arb_state_t state_d;
   port_idx_t  last_q;
   logic       lock_q;
   logic       hold1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock1;
         if (state_d != IDLE) begin
            last_q <= (state_d == GRANT0) ? 1'b0 : 1'b1;
         end
      end
   end

   always_comb begin
      state_d = IDLE;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      // A lock only carries over if port 1 actually held the grant last cycle.
      hold1   = ((state_q == GRANT1) || (state_q == LOCK1)) && lock_q && req1;

      if (force0) begin
         state_d = GRANT0;
      end else if (hold1) begin
         state_d = LOCK1;
      end else if (req0 && req1) begin
         state_d = (last_q == 1'b1) ? GRANT0 : GRANT1;
      end else if (req0) begin
         state_d = GRANT0;
      end else if (req1) begin
         state_d = GRANT1;
      end

      gnt0 = (state_d == GRANT0);
      gnt1 = (state_d == GRANT1) || (state_d == LOCK1);
   end

endmodule

// File: rtl/mem_dat_arbiter.sv
// Arbiter and access controller in front of the byte-addressed big-endian
// data memory: one word access per cycle, error checking, registered reads.
module mem_dat_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
   parameter int unsigned MAX_LOCK  = MAX_LOCK_DEF
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   input  logic        lock1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        err0,
   output logic        err1,
   output logic        esc_mem,
   output logic        read_mem,
   output logic [31:0] dst_mem,
   output logic [31:0] value,
   input  logic [31:0] out_dat
);

   localparam int CNT_W = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);

   logic             arb_gnt0;
   logic             arb_gnt1;
   logic             force0;
   logic [CNT_W-1:0] lock_cnt_q;

   logic             any_gnt;
   logic             sel_we;
   logic             sel_ok;
   logic [31:0]      sel_addr;
   logic [31:0]      sel_wdata;

   logic             vld0_p1;
   logic             vld1_p1;
   logic             err0_p1;
   logic             err1_p1;
   logic [31:0]      rdata0_p1;
   logic [31:0]      rdata1_p1;

   assign force0 = req0 && (lock_cnt_q == CNT_W'(MAX_LOCK));

   rr_arb2 u_rr_arb2 (
      .clock   (clock),
      .reset_n (reset_n),
      .req0    (req0),
      .req1    (req1),
      .lock1   (lock1),
      .force0  (force0),
      .gnt0    (arb_gnt0),
      .gnt1    (arb_gnt1)
   );

   // Grants are masked while reset is held so nothing reaches the memory.
   assign gnt0 = arb_gnt0 & reset_n;
   assign gnt1 = arb_gnt1 & reset_n;

   // Counts locked grants to port 1 that port 0 has been waiting through.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lock_cnt_q <= '0;
      end else if (gnt1 && lock1 && req0) begin
         lock_cnt_q <= lock_cnt_q + CNT_W'(1);
      end else begin
         lock_cnt_q <= '0;
      end
   end

   // ---- stage p0: select granted port and drive the memory ----
   assign any_gnt   = gnt0 | gnt1;
   assign sel_addr  = gnt1 ? addr1  : addr0;
   assign sel_wdata = gnt1 ? wdata1 : wdata0;
   assign sel_we    = gnt1 ? we1    : we0;
   assign sel_ok    = addr_ok(sel_addr, MEM_BYTES);

   assign dst_mem   = sel_addr;
   assign value     = sel_wdata;
   assign esc_mem   = any_gnt &  sel_we & sel_ok;
   assign read_mem  = any_gnt & ~sel_we & sel_ok;

   // ---- stage p1: registered response per port ----
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld0_p1   <= 1'b0;
         vld1_p1   <= 1'b0;
         err0_p1   <= 1'b0;
         err1_p1   <= 1'b0;
         rdata0_p1 <= '0;
         rdata1_p1 <= '0;
      end else begin
         vld0_p1 <= gnt0;
         vld1_p1 <= gnt1;
         err0_p1 <= gnt0 & ~sel_ok;
         err1_p1 <= gnt1 & ~sel_ok;
         // Successful writes leave rdata untouched; errors always return zero.
         if (gnt0) begin
            if (!sel_ok) begin
               rdata0_p1 <= '0;
            end else if (!sel_we) begin
               rdata0_p1 <= out_dat;
            end
         end
         if (gnt1) begin
            if (!sel_ok) begin
               rdata1_p1 <= '0;
            end else if (!sel_we) begin
               rdata1_p1 <= out_dat;
            end
         end
      end
   end

   assign rvalid0 = vld0_p1;
   assign rvalid1 = vld1_p1;
   assign err0    = err0_p1;
   assign err1    = err1_p1;
   assign rdata0  = rdata0_p1;
   assign rdata1  = rdata1_p1;

endmodule

// File: tb/tb_mem_dat_arbiter.sv
// Self-checking bench for mem_dat_arbiter: directed scenarios plus a
// randomized run against a behavioural arbitration/memory model.
`timescale 1ns/1ps
module tb_mem_dat_arbiter;

   localparam int unsigned MEMB = 2032;
   localparam int unsigned MAXL = 4;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
   logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, esc_mem, read_mem;
   logic [31:0] rdata0, rdata1, dst_mem, value, out_dat;

   int checks = 0;
   int errors = 0;

   // Big-endian byte memory standing in for MemDat.
   bit [7:0]    mem [0:2047];
   logic [10:0] ma;

   always #5 clock = ~clock;

   assign ma      = dst_mem[10:0];
   assign out_dat = {mem[ma], mem[ma + 11'd1], mem[ma + 11'd2], mem[ma + 11'd3]};

   always @(posedge clock) begin
      if (esc_mem) begin
         mem[ma]         <= value[31:24];
         mem[ma + 11'd1] <= value[23:16];
         mem[ma + 11'd2] <= value[15:8];
         mem[ma + 11'd3] <= value[7:0];
      end
   end

   mem_dat_arbiter #(.MEM_BYTES(MEMB), .MAX_LOCK(MAXL)) dut (
      .clock(clock), .reset_n(reset_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
      .err0(err0), .err1(err1), .esc_mem(esc_mem), .read_mem(read_mem),
      .dst_mem(dst_mem), .value(value), .out_dat(out_dat)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset_n = 0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1;
   endtask

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 9))
         0: return 32'h7E8;
         1: return 32'h7F0;
         2: return 32'h200 + $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
         3: return 32'hFFFF_FFFC;
         default: return 32'h200 + $urandom_range(0, 15) * 4;
      endcase
   endfunction

   task automatic test_reset();
      #1;
      reset_n = 0;
      req0 = 1; we0 = 1; addr0 = 32'h40; wdata0 = 32'h5555_AAAA;
      req1 = 1; addr1 = 32'h44;
      #2;
      checks++;
      if ({gnt0, gnt1, esc_mem, read_mem} !== 4'b0000) begin
         errors++; $display("FAIL reset_ctrl: gnt0/gnt1/esc/read=%b want 0000", {gnt0, gnt1, esc_mem, read_mem});
      end
      checks++;
      if ({rvalid0, rvalid1, err0, err1} !== 4'b0000) begin
         errors++; $display("FAIL reset_resp: rvalid0/1,err0/1=%b want 0000", {rvalid0, rvalid1, err0, err1});
      end
      checks++;
      if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
         errors++; $display("FAIL reset_rdata: rdata0=%h rdata1=%h want 0", rdata0, rdata1);
      end
      tick();
      checks++;
      if ({mem[64], mem[65], mem[66], mem[67]} !== 32'h0) begin
         errors++; $display("FAIL reset_no_write: mem[0x40]=%h want 0", {mem[64], mem[65], mem[66], mem[67]});
      end
      idle_inputs();
      tick();
      reset_n = 1;
   endtask

   task automatic test_uncontested();
      apply_reset();
      req0 = 1; we0 = 1; addr0 = 32'h40; wdata0 = 32'hDEAD_BEEF;
      #1;
      checks++;
      if ({gnt0, gnt1, esc_mem, read_mem} !== 4'b1010) begin
         errors++; $display("FAIL uc_wr_ctrl: gnt0/gnt1/esc/read=%b want 1010", {gnt0, gnt1, esc_mem, read_mem});
      end
      checks++;
      if (dst_mem !== 32'h40 || value !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL uc_wr_bus: dst=%h value=%h want 40 deadbeef", dst_mem, value);
      end
      tick();
      we0 = 0;
      #1;
      checks++;
      if ({gnt0, esc_mem, read_mem} !== 3'b101) begin
         errors++; $display("FAIL uc_rd_ctrl: gnt0/esc/read=%b want 101", {gnt0, esc_mem, read_mem});
      end
      checks++;
      if ({rvalid0, err0, rvalid1} !== 3'b100 || rdata0 !== 32'h0) begin
         errors++; $display("FAIL uc_wr_resp: rv0/err0/rv1=%b rdata0=%h want 100 0", {rvalid0, err0, rvalid1}, rdata0);
      end
      tick();
      idle_inputs();
      checks++;
      if (rvalid0 !== 1'b1 || err0 !== 1'b0 || rdata0 !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL uc_rd_resp: rv0=%b err0=%b rdata0=%h want 1 0 deadbeef", rvalid0, err0, rdata0);
      end
      tick();
      checks++;
      if (rvalid0 !== 1'b0) begin
         errors++; $display("FAIL uc_pulse: rvalid0=%b want 0", rvalid0);
      end
   endtask

   task automatic test_contention();
      logic [1:0] want;
      apply_reset();
      req0 = 1; req1 = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         want = (i % 2 == 0) ? 2'b10 : 2'b01;
         checks++;
         if ({gnt0, gnt1} !== want) begin
            errors++; $display("FAIL ct_gnt[%0d]: gnt0/gnt1=%b want %b", i, {gnt0, gnt1}, want);
         end
         if (i > 0) begin
            checks++;
            if ({rvalid0, rvalid1} !== ~want) begin
               errors++; $display("FAIL ct_rvalid[%0d]: rvalid0/1=%b want %b", i, {rvalid0, rvalid1}, ~want);
            end
         end
         tick();
      end
      idle_inputs();
      checks++;
      if ({rvalid0, rvalid1} !== 2'b01) begin
         errors++; $display("FAIL ct_rvalid_last: rvalid0/1=%b want 01", {rvalid0, rvalid1});
      end
   endtask

   task automatic test_lock_starve();
      int unsigned seq [6] = '{1, 1, 1, 1, 0, 1};
      apply_reset();
      req0 = 1;
      #1;
      checks++;
      if (gnt0 !== 1'b1) begin
         errors++; $display("FAIL lk_pre: gnt0=%b want 1", gnt0);
      end
      tick();
      req1 = 1; lock1 = 1; addr1 = 32'h4;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if ({gnt0, gnt1} !== ((seq[i] == 1) ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL lk_seq[%0d]: gnt0/gnt1=%b want port %0d", i, {gnt0, gnt1}, seq[i]);
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_errors();
      apply_reset();
      req1 = 1; we1 = 1; addr1 = 32'h42; wdata1 = 32'h1111_1111;
      #1;
      checks++;
      if ({gnt1, esc_mem, read_mem} !== 3'b100) begin
         errors++; $display("FAIL er_mis_wr: gnt1/esc/read=%b want 100", {gnt1, esc_mem, read_mem});
      end
      tick();
      we1 = 0; addr1 = 32'h7F0;
      #1;
      checks++;
      if ({gnt1, esc_mem, read_mem} !== 3'b100) begin
         errors++; $display("FAIL er_oob_rd: gnt1/esc/read=%b want 100", {gnt1, esc_mem, read_mem});
      end
      checks++;
      if ({rvalid1, err1} !== 2'b11) begin
         errors++; $display("FAIL er_mis_resp: rvalid1/err1=%b want 11", {rvalid1, err1});
      end
      tick();
      we1 = 1; addr1 = 32'h7EC; wdata1 = 32'hCAFE_F00D;
      #1;
      checks++;
      if (esc_mem !== 1'b1 || dst_mem !== 32'h7EC) begin
         errors++; $display("FAIL er_last_wr: esc=%b dst=%h want 1 7ec", esc_mem, dst_mem);
      end
      checks++;
      if ({rvalid1, err1} !== 2'b11 || rdata1 !== 32'h0) begin
         errors++; $display("FAIL er_oob_resp: rvalid1/err1=%b rdata1=%h want 11 0", {rvalid1, err1}, rdata1);
      end
      tick();
      we1 = 0;
      #1;
      checks++;
      if (read_mem !== 1'b1 || {rvalid1, err1} !== 2'b10) begin
         errors++; $display("FAIL er_last_rd: read=%b rvalid1/err1=%b want 1 10", read_mem, {rvalid1, err1});
      end
      tick();
      idle_inputs();
      checks++;
      if ({rvalid1, err1} !== 2'b10 || rdata1 !== 32'hCAFE_F00D) begin
         errors++; $display("FAIL er_last_resp: rvalid1/err1=%b rdata1=%h want 10 cafef00d", {rvalid1, err1}, rdata1);
      end
   endtask

   task automatic test_reset_mid_read();
      apply_reset();
      req0 = 1; we0 = 1; addr0 = 32'h80; wdata0 = 32'h1234_5678;
      tick();
      we0 = 0;
      tick();
      checks++;
      if (rvalid0 !== 1'b1 || rdata0 !== 32'h1234_5678) begin
         errors++; $display("FAIL rm_pre: rvalid0=%b rdata0=%h want 1 12345678", rvalid0, rdata0);
      end
      we0 = 1; wdata0 = 32'hFFFF_FFFF;
      reset_n = 0;
      #1;
      checks++;
      if ({rvalid0, err0} !== 2'b00 || rdata0 !== 32'h0) begin
         errors++; $display("FAIL rm_drop: rvalid0/err0=%b rdata0=%h want 00 0", {rvalid0, err0}, rdata0);
      end
      checks++;
      if ({gnt0, esc_mem} !== 2'b00) begin
         errors++; $display("FAIL rm_force: gnt0/esc=%b want 00", {gnt0, esc_mem});
      end
      tick();
      checks++;
      if ({mem[128], mem[129], mem[130], mem[131]} !== 32'h1234_5678) begin
         errors++; $display("FAIL rm_nowrite: mem[0x80]=%h want 12345678", {mem[128], mem[129], mem[130], mem[131]});
      end
      idle_inputs();
      tick();
      reset_n = 1;
      req0 = 1; req1 = 1;
      #1;
      checks++;
      if ({gnt0, gnt1} !== 2'b10) begin
         errors++; $display("FAIL rm_prio: gnt0/gnt1=%b want 10", {gnt0, gnt1});
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_random();
      bit [31:0]   ref_mem [0:507];
      bit          pend [2];
      bit          pwe  [2];
      logic [31:0] pa   [2];
      logic [31:0] pd   [2];
      bit          e_rv [2];
      bit          e_err[2];
      logic [31:0] e_rd [2];
      int          m_last, m_run, g;
      bit          m_lock, gwe, gok;
      logic [31:0] ga, gd;

      apply_reset();
      m_last = 1; m_run = 0; m_lock = 0;
      pend = '{0, 0}; pwe = '{0, 0}; pa = '{32'h0, 32'h0}; pd = '{32'h0, 32'h0};
      e_rv = '{0, 0}; e_err = '{0, 0}; e_rd = '{32'h0, 32'h0};

      for (int n = 0; n < 800; n++) begin
         checks++;
         if (rvalid0 !== e_rv[0] || err0 !== e_err[0] || rdata0 !== e_rd[0]) begin
            errors++; $display("FAIL rnd_resp0[%0d]: rv=%b err=%b rdata=%h want %b %b %h",
                               n, rvalid0, err0, rdata0, e_rv[0], e_err[0], e_rd[0]);
         end
         checks++;
         if (rvalid1 !== e_rv[1] || err1 !== e_err[1] || rdata1 !== e_rd[1]) begin
            errors++; $display("FAIL rnd_resp1[%0d]: rv=%b err=%b rdata=%h want %b %b %h",
                               n, rvalid1, err1, rdata1, e_rv[1], e_err[1], e_rd[1]);
         end

         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(0, 3) != 0) begin
               pend[p] = 1;
               pwe[p]  = 1'($urandom_range(0, 1));
               pa[p]   = pick_addr();
               pd[p]   = $urandom;
            end
         end
         req0 = pend[0]; we0 = pwe[0]; addr0 = pa[0]; wdata0 = pd[0];
         req1 = pend[1]; we1 = pwe[1]; addr1 = pa[1]; wdata1 = pd[1];
         lock1 = ($urandom_range(0, 3) != 0);
         #1;

         // Who should own the memory this cycle.
         if (pend[0] && m_run == int'(MAXL))      g = 0;
         else if (m_lock && pend[1])              g = 1;
         else if (pend[0] && pend[1])             g = (m_last == 1) ? 0 : 1;
         else if (pend[0])                        g = 0;
         else if (pend[1])                        g = 1;
         else                                     g = -1;

         checks++;
         if ({gnt0, gnt1} !== {g == 0, g == 1}) begin
            errors++; $display("FAIL rnd_gnt[%0d]: gnt0/gnt1=%b want port %0d", n, {gnt0, gnt1}, g);
         end

         ga  = (g == 1) ? pa[1]  : pa[0];
         gd  = (g == 1) ? pd[1]  : pd[0];
         gwe = (g == 1) ? pwe[1] : pwe[0];
         gok = (ga % 4 == 0) && (ga <= MEMB - 4);
         checks++;
         if (dst_mem !== ga || value !== gd ||
             esc_mem !== (g >= 0 && gwe && gok) || read_mem !== (g >= 0 && !gwe && gok)) begin
            errors++; $display("FAIL rnd_mem[%0d]: dst=%h val=%h esc=%b rd=%b want %h %h %b %b", n,
                               dst_mem, value, esc_mem, read_mem, ga, gd,
                               (g >= 0 && gwe && gok), (g >= 0 && !gwe && gok));
         end

         m_run  = (g == 1 && lock1 && pend[0]) ? m_run + 1 : 0;
         m_lock = (g == 1 && lock1);
         e_rv   = '{0, 0};
         e_err  = '{0, 0};
         if (g >= 0) begin
            m_last   = g;
            e_rv[g]  = 1;
            e_err[g] = !gok;
            if (!gok)      e_rd[g] = 32'h0;
            else if (!gwe) e_rd[g] = ref_mem[ga / 4];
            else           ref_mem[ga / 4] = gd;
            pend[g] = 0;
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_uncontested();
      test_contention();
      test_lock_starve();
      test_errors();
      test_reset_mid_read();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
